// File: rtl/fifo_vec_reader.sv
// Read-side controller for the layernorm element FIFO: pops a row of elements and packs them into
// VEC_LEN-lane vectors on a valid/ready handshake. Optional stall counter: FIFO_VEC_READER_STALL_CNT_EN.
module fifo_vec_reader #(
  parameter int WIDTH   = 8,
  parameter int VEC_LEN = 4,
  parameter int LEN_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [LEN_W-1:0]         row_len,
  output logic                     fifo_rd_en,
  input  logic                     fifo_empty,
  input  logic [WIDTH-1:0]         fifo_dout,
  output logic [VEC_LEN*WIDTH-1:0] vec_data,
  output logic [VEC_LEN-1:0]       vec_mask,
  output logic                     vec_valid,
  input  logic                     vec_ready,
  output logic                     vec_last,
  output logic                     busy,
  output logic                     done
`ifdef FIFO_VEC_READER_STALL_CNT_EN
  ,
  output logic [31:0]              stall_cnt
`endif
);

  localparam int CW = $clog2(VEC_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_PRESENT, S_DONE} state_e;

  state_e                   state_q, state_d;
  logic [LEN_W-1:0]         remaining_q, remaining_d;
  logic [CW-1:0]            target_q, target_d;
  logic [CW-1:0]            issued_q, issued_d;
  logic [CW-1:0]            captured_q, captured_d;
  logic                     pend_q, pend_d;
  logic [VEC_LEN*WIDTH-1:0] lanes_q, lanes_d;

  function automatic logic [CW-1:0] min_target(input logic [LEN_W-1:0] len);
    if (len >= LEN_W'(VEC_LEN)) return CW'(VEC_LEN);
    else return CW'(len);
  endfunction

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    target_d    = target_q;
    issued_d    = issued_q;
    captured_d  = captured_q;
    pend_d      = 1'b0;
    lanes_d     = lanes_q;
    fifo_rd_en  = 1'b0;
    vec_valid   = 1'b0;
    vec_last    = 1'b0;
    vec_mask    = '0;
    done        = 1'b0;
    busy        = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          remaining_d = row_len;
          target_d    = min_target(row_len);
          issued_d    = '0;
          captured_d  = '0;
          lanes_d     = '0;
          state_d     = (row_len == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        fifo_rd_en = !fifo_empty && (issued_q < target_q);
        pend_d     = fifo_rd_en;
        if (fifo_rd_en) issued_d = issued_q + 1'b1;
        // pend_q marks that fifo_dout carries the element read last cycle
        if (pend_q) begin
          for (int i = 0; i < VEC_LEN; i++) begin
            if (captured_q == CW'(i)) lanes_d[i*WIDTH +: WIDTH] = fifo_dout;
          end
          captured_d = captured_q + 1'b1;
          if (captured_q + 1'b1 == target_q) begin
            state_d     = S_PRESENT;
            remaining_d = remaining_q - LEN_W'(target_q);
          end
        end
      end
      S_PRESENT: begin
        vec_valid = 1'b1;
        vec_last  = (remaining_q == '0);
        for (int i = 0; i < VEC_LEN; i++) vec_mask[i] = (CW'(i) < target_q);
        if (vec_ready) begin
          lanes_d    = '0;
          issued_d   = '0;
          captured_d = '0;
          if (remaining_q == '0) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_FILL;
            target_d = min_target(remaining_q);
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      target_q    <= '0;
      issued_q    <= '0;
      captured_q  <= '0;
      pend_q      <= 1'b0;
      lanes_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      target_q    <= target_d;
      issued_q    <= issued_d;
      captured_q  <= captured_d;
      pend_q      <= pend_d;
      lanes_q     <= lanes_d;
    end
  end

  assign vec_data = lanes_q;

`ifdef FIFO_VEC_READER_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && start) begin
      stall_d = '0;
    end else if ((state_q == S_FILL && fifo_empty && issued_q < target_q) ||
                 (state_q == S_PRESENT && !vec_ready)) begin
      stall_d = sat_inc(stall_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_fifo_vec_reader.sv
// Directed bench for fifo_vec_reader with a 1-cycle-latency FIFO model and hand-computed vectors.
module tb_fifo_vec_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] row_len = '0;
  logic        fifo_rd_en;
  logic        fifo_empty;
  logic [7:0]  fifo_dout = '0;
  logic [31:0] vec_data;
  logic [3:0]  vec_mask;
  logic        vec_valid;
  logic        vec_ready = 1'b1;
  logic        vec_last;
  logic        busy;
  logic        done;
`ifdef FIFO_VEC_READER_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  fifo_vec_reader #(.WIDTH(8), .VEC_LEN(4), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .row_len(row_len),
    .fifo_rd_en(fifo_rd_en), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .vec_data(vec_data), .vec_mask(vec_mask), .vec_valid(vec_valid),
    .vec_ready(vec_ready), .vec_last(vec_last), .busy(busy), .done(done)
`ifdef FIFO_VEC_READER_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model: pop on rd_en, data visible the following cycle, zero otherwise
  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end else begin
      fifo_dout <= '0;
    end
  end

  int rd_cnt = 0;
  int done_cnt = 0;
  int viol = 0;
  always @(negedge clk) begin
    if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (fifo_rd_en && (fifo_empty || vec_valid)) viol <= viol + 1;
  end

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] gd [0:3];
  logic [3:0]  gm [0:3];
  logic        gl [0:3];
  int nvec, nrd, valid_at, done_at, viol0;
  bit timed_out;

  task automatic push(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic pulse_start(input logic [15:0] len);
    @(posedge clk); #1;
    start = 1'b1;
    row_len = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_row(input logic [15:0] len, input int max_cyc);
    int rd0;
    nvec = 0; valid_at = -1; done_at = -1; timed_out = 1'b1;
    rd0 = rd_cnt;
    viol0 = viol;
    pulse_start(len);
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      if (vec_valid && valid_at < 0) valid_at = c;
      if (vec_valid && vec_ready && nvec < 4) begin
        gd[nvec] = vec_data; gm[nvec] = vec_mask; gl[nvec] = vec_last;
        nvec++;
      end
      if (done) begin
        done_at = c;
        timed_out = 1'b0;
        break;
      end
    end
    #1;
    nrd = rd_cnt - rd0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, vec_valid, vec_last, done, fifo_rd_en, vec_mask, vec_data} !== 41'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h required 0",
               {busy, vec_valid, vec_last, done, fifo_rd_en, vec_mask, vec_data});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, vec_valid, done, fifo_rd_en} !== 4'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset got %b required 0000", {busy, vec_valid, done, fifo_rd_en});
    end
  endtask

  task automatic test_basic;
    int d0;
    for (int i = 1; i <= 8; i++) push(8'(i));
    vec_ready = 1'b1;
    d0 = done_cnt;
    run_row(16'd8, 60);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout got timeout required done"); end
    n_checks++; if (nvec !== 2) begin n_fail++; $display("FAIL basic_nvec got %0d required 2", nvec); end
    n_checks++; if (gd[0] !== 32'h04030201) begin n_fail++; $display("FAIL basic_v0_data got %h required 04030201", gd[0]); end
    n_checks++; if ({gm[0], gl[0]} !== 5'b1111_0) begin n_fail++; $display("FAIL basic_v0_mask_last got %b required 11110", {gm[0], gl[0]}); end
    n_checks++; if (gd[1] !== 32'h08070605) begin n_fail++; $display("FAIL basic_v1_data got %h required 08070605", gd[1]); end
    n_checks++; if ({gm[1], gl[1]} !== 5'b1111_1) begin n_fail++; $display("FAIL basic_v1_mask_last got %b required 11111", {gm[1], gl[1]}); end
    n_checks++; if (nrd !== 8) begin n_fail++; $display("FAIL basic_rd_cycles got %0d required 8", nrd); end
    n_checks++; if (valid_at !== 5) begin n_fail++; $display("FAIL basic_latency got %0d required 5", valid_at); end
    n_checks++; if (done_at !== 12) begin n_fail++; $display("FAIL basic_done_cycle got %0d required 12", done_at); end
    repeat (3) @(negedge clk);
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL basic_done_pulses got %0d required 1", done_cnt - d0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got %b required 0", busy); end
  endtask

  task automatic test_partial;
    for (int i = 0; i < 6; i++) push(8'h11 + 8'(i));
    vec_ready = 1'b1;
    run_row(16'd6, 60);
    n_checks++; if (timed_out || nvec !== 2) begin n_fail++; $display("FAIL partial_nvec got %0d to=%0b required 2", nvec, timed_out); end
    n_checks++; if (gd[0] !== 32'h14131211) begin n_fail++; $display("FAIL partial_v0_data got %h required 14131211", gd[0]); end
    n_checks++; if (gd[1] !== 32'h00001615) begin n_fail++; $display("FAIL partial_v1_data got %h required 00001615", gd[1]); end
    n_checks++; if ({gm[1], gl[1]} !== 5'b0011_1) begin n_fail++; $display("FAIL partial_v1_mask_last got %b required 00111", {gm[1], gl[1]}); end
    n_checks++; if (nrd !== 6) begin n_fail++; $display("FAIL partial_rd_cycles got %0d required 6", nrd); end
  endtask

  task automatic test_stall;
    bit seen;
    for (int i = 0; i < 4; i++) push(8'h31 + 8'(i));
    vec_ready = 1'b0;
    viol0 = viol;
    pulse_start(16'd4);
    seen = 1'b0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      if (vec_valid) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL stall_valid_timeout got no vec_valid required vec_valid");
    end else begin
      for (int k = 0; k < 5; k++) begin
        if (k > 0) @(negedge clk);
        n_checks++;
        if ({vec_valid, vec_last, vec_mask, vec_data, fifo_rd_en} !== {1'b1, 1'b1, 4'hF, 32'h34333231, 1'b0}) begin
          n_fail++;
          $display("FAIL stall_hold_%0d got v=%b l=%b m=%h d=%h rd=%b required v=1 l=1 m=f d=34333231 rd=0",
                   k, vec_valid, vec_last, vec_mask, vec_data, fifo_rd_en);
        end
      end
      @(posedge clk); #1;
`ifdef FIFO_VEC_READER_STALL_CNT_EN
      n_checks++;
      if (stall_cnt !== 32'd5) begin n_fail++; $display("FAIL stall_cnt got %0d required 5", stall_cnt); end
`endif
      vec_ready = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      n_checks++; if (!seen) begin n_fail++; $display("FAIL stall_done_timeout got no done required done"); end
    end
    n_checks++; if (viol !== viol0) begin n_fail++; $display("FAIL stall_rd_violations got %0d required 0", viol - viol0); end
  endtask

  task automatic test_empty_fifo;
    vec_ready = 1'b1;
    fork
      begin
        for (int i = 1; i <= 4; i++) begin
          repeat (3) @(posedge clk);
          #1 push(8'(i));
        end
      end
      run_row(16'd4, 80);
    join
    n_checks++; if (timed_out || nvec !== 1) begin n_fail++; $display("FAIL empty_nvec got %0d to=%0b required 1", nvec, timed_out); end
    n_checks++; if (gd[0] !== 32'h04030201) begin n_fail++; $display("FAIL empty_v0_data got %h required 04030201", gd[0]); end
    n_checks++; if (viol !== viol0) begin n_fail++; $display("FAIL empty_rd_while_empty got %0d required 0", viol - viol0); end
    n_checks++; if (nrd !== 4) begin n_fail++; $display("FAIL empty_rd_cycles got %0d required 4", nrd); end
  endtask

  task automatic test_zero_len;
    run_row(16'd0, 10);
    n_checks++; if (done_at !== 0) begin n_fail++; $display("FAIL zero_done_cycle got %0d required 0", done_at); end
    n_checks++; if (nrd !== 0) begin n_fail++; $display("FAIL zero_rd_cycles got %0d required 0", nrd); end
    n_checks++; if (valid_at !== -1) begin n_fail++; $display("FAIL zero_valid got %0d required -1", valid_at); end
  endtask

  task automatic test_start_busy;
    int d0, r0;
    d0 = done_cnt; r0 = rd_cnt;
    @(posedge clk); #1;
    start = 1'b1; row_len = 16'd0;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if ({done, busy} !== 2'b11) begin n_fail++; $display("FAIL busy_done_state got %b required 11", {done, busy}); end
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL busy_single_done got %0d required 1", done_cnt - d0); end
    n_checks++; if ({busy, vec_valid} !== 2'b00 || rd_cnt !== r0) begin
      n_fail++; $display("FAIL busy_second_row got busy=%b valid=%b reads=%0d required 0 0 0", busy, vec_valid, rd_cnt - r0);
    end
  endtask

  task automatic test_reset_mid_fill;
    int r0;
    for (int i = 0; i < 8; i++) push(8'h21 + 8'(i));
    vec_ready = 1'b1;
    r0 = rd_cnt;
    pulse_start(16'd8);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, vec_valid, vec_last, done, fifo_rd_en, vec_mask, vec_data} !== 41'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs got %h required 0",
               {busy, vec_valid, vec_last, done, fifo_rd_en, vec_mask, vec_data});
    end
    n_checks++; if (rd_cnt - r0 !== 2) begin n_fail++; $display("FAIL midreset_reads got %0d required 2", rd_cnt - r0); end
    run_row(16'd4, 40);
    n_checks++; if (timed_out || nvec !== 1) begin n_fail++; $display("FAIL midreset_nvec got %0d to=%0b required 1", nvec, timed_out); end
    n_checks++; if ({gd[0], gm[0], gl[0]} !== {32'h26252423, 4'hF, 1'b1}) begin
      n_fail++; $display("FAIL midreset_vector got %h m=%h l=%b required 26252423 m=f l=1", gd[0], gm[0], gl[0]);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_partial;
    test_stall;
    test_empty_fifo;
    test_zero_len;
    test_start_busy;
    test_reset_mid_fill;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish required finish");
    $fatal(1, "global timeout");
  end
endmodule

// File: doc/fifo_vec_reader.md
Name: fifo_vec_reader

Overview:
- Read-side controller for the layernorm element FIFO.
- Pops a row of row_len WIDTH-bit elements through the FIFO's rd_en/empty/dout interface and packs them into VEC_LEN-lane vectors.
- Presents each vector downstream on a valid/ready handshake toward the vector datapath.
- The final vector of a row may be partial; a lane mask marks its valid lanes.

Parameters:
- WIDTH, 8, element width; must match the FIFO WIDTH.
- VEC_LEN, 4, lanes per output vector; must be at least 1.
- LEN_W, 16, width of row_len.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to read one row; ignored while busy=1.
- row_len  in  LEN_W  element count; sampled only when start is accepted.
- fifo_rd_en  out  1  read strobe to the FIFO.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  WIDTH  FIFO read data; valid in the cycle after an accepted fifo_rd_en, zero otherwise.
- vec_data  out  VEC_LEN*WIDTH  packed vector; lane i is bits [i*WIDTH +: WIDTH]; lane 0 holds the earliest element.
- vec_mask  out  VEC_LEN  bit i set means lane i is valid.
- vec_valid  out  1  vector available.
- vec_ready  in  1  downstream accepts the vector.
- vec_last  out  1  vector is the row's final vector; qualified by vec_valid.
- busy  out  1  a row is in progress (state is not IDLE).
- done  out  1  one-cycle pulse after the row completes.

Behaviour:
- Reset (rst=1 at a clock edge): state to IDLE; all counters cleared; fifo_rd_en, vec_valid, vec_last, busy and done to 0; vec_data and vec_mask to 0.
  - Reset mid-row abandons the row.
  - A read already issued to the FIFO is consumed and discarded; FIFO state itself is untouched.
- State IDLE:
  - start=1 latches remaining=row_len and sets busy the next cycle.
  - row_len=0: go to DONE, no FIFO reads, no vectors.
  - Otherwise go to FILL.
- State FILL:
  - target = min(VEC_LEN, remaining), fixed on entry.
  - fifo_rd_en = !fifo_empty && (issued < target); it is combinational on fifo_empty and never asserted while empty.
  - Read latency is 1: the element read at cycle t is captured from fifo_dout at edge t+1 into lane captured, then captured increments.
  - A capture and a new issue may occur in the same cycle, so throughput is one element per cycle while the FIFO is non-empty.
  - When captured reaches target, go to PRESENT; remaining decrements by target.
  - Unfilled lanes are zero.
- State PRESENT:
  - vec_valid=1; vec_mask has the low target bits set; vec_last = (remaining==0).
  - vec_data, vec_mask and vec_last are held stable until vec_ready=1.
  - No FIFO reads are issued in this state.
  - On handshake (vec_valid && vec_ready): clear lanes and counters. If remaining==0 go to DONE, else go to FILL.
- State DONE:
  - done=1 for exactly one cycle; go to IDLE with busy=0.
  - A start in this cycle is ignored.
- Counters: remaining is LEN_W bits and never underflows. issued and captured are $clog2(VEC_LEN+1) bits.
- Vector count per row = ceil(row_len/VEC_LEN).
- Minimum latency from start to the first vec_valid, with a non-empty FIFO: 2 + VEC_LEN cycles.

Optional Feature:
- Macro: FIFO_VEC_READER_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt (out, 32 bits).
  - Increments each cycle in FILL with fifo_empty=1 and issued<target, plus each cycle in PRESENT with vec_ready=0.
  - Saturates at 2^32-1.
  - Cleared by rst and on accepted start.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- VEC_LEN=4, FIFO preloaded 0x01..0x08, row_len=8, vec_ready=1 -> two vectors:
  - vec_data=0x04030201, mask=4'hF, last=0.
  - Then 0x08070605, mask=4'hF, last=1.
  - done pulses once; exactly 8 fifo_rd_en cycles.
- row_len=6 with data 0x11..0x16 -> second vector vec_data=0x00001615, vec_mask=4'b0011, vec_last=1.
- row_len=4 with vec_ready held 0 for 5 cycles -> vec_valid and vec_data stable all 5 cycles; no fifo_rd_en while in PRESENT; stall_cnt=5 with the macro defined.
- FIFO initially empty, elements pushed one every 3 cycles, row_len=4 -> fifo_rd_en never high while fifo_empty=1; vector 0x..04030201 is correct.
- row_len=0 -> no fifo_rd_en; done high exactly 1 cycle after the start edge; vec_valid never asserts. A start issued while busy is ignored: no second row, a single done.
- rst asserted mid-FILL after 2 reads -> next cycle state=IDLE and all outputs 0. A new start with row_len=4 produces a correct vector from the remaining FIFO data.
